microstepper_chopper_nch: RTL and testbench
===========================================

Name: microstepper_chopper_nch

Overview:
Parametrised N-channel successor of the two-phase microstepper switch controller. It owns its blank, off, minimum-on and dead-time timers per channel, where the previous block took externally supplied timers. Per channel it runs a peak-current chopper FSM with fast then slow decay, and inserts dead time per bridge leg. It sits between the microstep commutation logic (commanded leg polarity) and the gate-driver pins, with the analog current comparators as feedback.

Parameters:
NUM_CH, 2, number of H-bridge channels; each channel has 2 legs
OFFTIME_W, 10, width of off-time counter and fast-decay threshold
BLANK_W, 8, width of blank-time counter
MINON_W, 8, width of minimum-on counter
DEAD_W, 4, width of dead-time counter

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
enable  in  1  1 = chopper running; 0 = all gates off, FSMs to IDLE
s_cmd  in  2*NUM_CH  commanded leg polarity; bit 2c+k = channel c, leg k; 1 = high side, 0 = low side
analog_cmp  in  NUM_CH  asynchronous peak-current comparator per channel
config_offtime  in  OFFTIME_W  off-time load value (cycles)
config_fastdecay_threshold  in  OFFTIME_W  fast decay while off counter >= this
config_blanktime  in  BLANK_W  comparator blanking after each on start
config_minon  in  MINON_W  minimum legal on time before a trip
config_deadtime  in  DEAD_W  both-off cycles per leg side change
config_invert_highside  in  1  XOR on all s_h pins
config_invert_lowside  in  1  XOR on all s_l pins
clear_fault  in  1  single-cycle pulse; clears all sticky faults
s_h  out  2*NUM_CH  high-side gate pins
s_l  out  2*NUM_CH  low-side gate pins
fault_ch  out  NUM_CH  sticky per-channel fault
fault  out  1  OR of fault_ch

Behaviour:
- Gate registers h_on/l_on are active-high. Pins: s_h = config_invert_highside ^ h_on, s_l = config_invert_lowside ^ l_on.
- Reset: all h_on/l_on = 0, fault_ch = 0, all counters = 0, FSMs in IDLE, comparator synchronisers cleared.
- analog_cmp passes through a 2-flop synchroniser per channel; only the synchronised value (cmp_s) is used.
- Per-channel FSM (registered) has states IDLE, BLANK, ON, FAST, SLOW, FAULT.
  - IDLE: leaves for BLANK when enable = 1 and no fault is present. On entry to BLANK, load blank counter = config_blanktime and clear the on counter.
  - BLANK: cmp_s is ignored. Blank counter decrements; go to ON when it is 0. The on counter increments, saturating.
  - ON: on counter increments, saturating. On cmp_s = 1:
    - if on counter < config_minon, go to FAULT and set fault_ch;
    - otherwise go to FAST and load off counter = config_offtime.
  - FAST/SLOW: off counter decrements. State is FAST while counter >= threshold and SLOW otherwise. At counter 0, go to BLANK. cmp_s is ignored.
  - FAULT: held until clear_fault, then IDLE. Reset also exits FAULT.
  - enable = 0 in any state except FAULT forces IDLE next cycle.
- Per-leg target by state:
  - IDLE/FAULT: both off.
  - BLANK/ON: follow s_cmd (1 → high on, 0 → low on).
  - FAST: inverted s_cmd.
  - SLOW: low on, high off.
- Any fault_ch = 1 forces every leg of every channel off.
- The target is never both-on. Dead time per leg:
  - When the target side differs from the side currently on, drive both off for config_deadtime cycles, then the new side.
  - Target both-off is applied immediately.
  - config_deadtime = 0 switches directly.
  - If the target changes again during dead time, restart the count.
- Latency with deadtime 0: analog_cmp stable before edge e1 → FSM changes at e3 → gates at e4.
- An s_cmd change during FAST/SLOW takes effect at the next BLANK; FAST uses the live inverted s_cmd.
- config_offtime = 0: FAST/SLOW lasts 1 cycle. config_blanktime = 0: BLANK lasts 1 cycle.
- config_fastdecay_threshold = 0: all off time is fast. Threshold > config_offtime: all off time is slow.
- Simultaneous clear_fault and new trip: the trip wins and the fault stays set.

Decomposition:
- Package microstepper_pkg holds:
  - the chopper state enum (IDLE, BLANK, ON, FAST, SLOW, FAULT; 3-bit encoding);
  - the leg-target encoding (OFF, HIGH, LOW);
  - parameter defaults.
- One sub-module, microstepper_chopper_channel: synchroniser, FSM, blank/on/off counters and two dead-time legs for one channel. It is instantiated NUM_CH times by generate.
- The top level does fault OR-ing, global fault override and pin inversion.

Test Plan:
- Reset, inverts = 0 → all s_h/s_l = 0. Inverts = 1 → all pins = 1. fault = 0.
- NUM_CH = 2; enable = 1; blank = 4, minon = 2, offtime = 10, threshold = 6, deadtime = 2; s_cmd = 4'b0001.
  - Expect a dead-time gap of exactly 2 cycles, then ch0 leg0 high, leg1 low, after BLANK.
  - Assert cmp0 after blank → ch0 legs inverted for 5 cycles (counter 10..6), then both low for 5 cycles, then BLANK.
  - Ch1 is unaffected throughout.
- Pulse cmp0 during BLANK → ignored. Assert cmp0 1 cycle into ON with minon = 8 → fault_ch = 2'b01, fault = 1, all 8 gates off. clear_fault → BLANK restart.
- Toggle s_cmd leg0 every cycle with deadtime = 3 → h_on and l_on are never both 1, and the count restarts on each change.
- Assert resetn low mid-FAST → all gates off immediately (asynchronously). After release, state is IDLE and the counters are 0.
- enable = 0 mid-ON → gates off 1 cycle later. Re-enable → full blank period before cmp is honoured.

Source files
------------

// File: rtl/microstepper_pkg.sv
// Shared types and defaults for the N-channel microstepper chopper.
//   chop_state_t : per-channel peak-current chopper state (3-bit encoding)
//   leg_t        : per-leg gate target (both off, high side on, low side on)
//   cmd_to_leg   : maps a commanded leg polarity bit to a leg target
package microstepper_pkg;

  localparam int DEF_NUM_CH    = 2;
  localparam int DEF_OFFTIME_W = 10;
  localparam int DEF_BLANK_W   = 8;
  localparam int DEF_MINON_W   = 8;
  localparam int DEF_DEAD_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BLANK = 3'd1,
    ST_ON    = 3'd2,
    ST_FAST  = 3'd3,
    ST_SLOW  = 3'd4,
    ST_FAULT = 3'd5
  } chop_state_t;

  typedef enum logic [1:0] {
    LEG_OFF  = 2'd0,
    LEG_HIGH = 2'd1,
    LEG_LOW  = 2'd2
  } leg_t;

  // Polarity 1 selects the high side, 0 the low side.
  function automatic leg_t cmd_to_leg(input logic cmd);
    if (cmd) begin
      return LEG_HIGH;
    end else begin
      return LEG_LOW;
    end
  endfunction

endpackage

// File: rtl/microstepper_chopper_channel.sv
// One H-bridge channel: comparator synchroniser, peak-current chopper FSM
// (blank / on / fast decay / slow decay / fault), its blank, on and off
// counters, and a dead-time sequencer for each of the two bridge legs.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   enable               0 forces the FSM to IDLE (except from FAULT)
//   cmd[1:0]             commanded polarity per leg (1 = high side)
//   cmp_async            raw peak-current comparator
//   force_off            a fault anywhere in the block: all legs off
//   config_*             timing configuration (cycles)
//   clear_fault          clears the sticky fault and leaves FAULT
//   h_on/l_on[1:0]       active-high gate registers per leg
//   fault_ch             sticky trip flag of this channel
module microstepper_chopper_channel
  import microstepper_pkg::*;
#(
  parameter int OFFTIME_W = DEF_OFFTIME_W,
  parameter int BLANK_W   = DEF_BLANK_W,
  parameter int MINON_W   = DEF_MINON_W,
  parameter int DEAD_W    = DEF_DEAD_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [1:0]           cmd,
  input  logic                 cmp_async,
  input  logic                 force_off,
  input  logic [OFFTIME_W-1:0] config_offtime,
  input  logic [OFFTIME_W-1:0] config_fastdecay_threshold,
  input  logic [BLANK_W-1:0]   config_blanktime,
  input  logic [MINON_W-1:0]   config_minon,
  input  logic [DEAD_W-1:0]    config_deadtime,
  input  logic                 clear_fault,
  output logic [1:0]           h_on,
  output logic [1:0]           l_on,
  output logic                 fault_ch
);

  localparam logic [BLANK_W-1:0]   BLANK_ONE = {{(BLANK_W-1){1'b0}}, 1'b1};
  localparam logic [OFFTIME_W-1:0] OFF_ONE   = {{(OFFTIME_W-1){1'b0}}, 1'b1};
  localparam logic [MINON_W-1:0]   MINON_ONE = {{(MINON_W-1){1'b0}}, 1'b1};
  localparam logic [MINON_W-1:0]   MINON_MAX = {MINON_W{1'b1}};
  localparam logic [DEAD_W-1:0]    DEAD_ONE  = {{(DEAD_W-1){1'b0}}, 1'b1};
  localparam logic [DEAD_W-1:0]    DEAD_ZERO = {DEAD_W{1'b0}};

  logic                 cmp_meta_r;
  logic                 cmp_sync_r;
  chop_state_t          state_r;
  chop_state_t          state_nxt_s;
  logic [BLANK_W-1:0]   blank_cnt_r;
  logic [BLANK_W-1:0]   blank_nxt_s;
  logic [MINON_W-1:0]   on_cnt_r;
  logic [MINON_W-1:0]   on_nxt_s;
  logic [MINON_W-1:0]   on_inc_s;
  logic [OFFTIME_W-1:0] off_cnt_r;
  logic [OFFTIME_W-1:0] off_nxt_s;
  logic [OFFTIME_W-1:0] off_dec_s;
  logic                 fault_r;
  logic                 fault_nxt_s;
  logic                 trip_s;

  assign on_inc_s  = (on_cnt_r == MINON_MAX) ? on_cnt_r : (on_cnt_r + MINON_ONE);
  assign off_dec_s = off_cnt_r - OFF_ONE;
  assign fault_ch  = fault_r;

  // Two-flop synchroniser for the asynchronous comparator.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmp_meta_r <= 1'b0;
      cmp_sync_r <= 1'b0;
    end else begin
      cmp_meta_r <= cmp_async;
      cmp_sync_r <= cmp_meta_r;
    end
  end

  // Chopper next-state and counter update. Blank and off phases end on the
  // cycle their counter would reach zero, so a load of 0 or 1 gives one cycle.
  always_comb begin
    state_nxt_s = state_r;
    blank_nxt_s = blank_cnt_r;
    on_nxt_s    = on_cnt_r;
    off_nxt_s   = off_cnt_r;
    trip_s      = 1'b0;
    if (state_r == ST_FAULT) begin
      if (clear_fault) begin
        state_nxt_s = ST_IDLE;
      end else begin
        state_nxt_s = ST_FAULT;
      end
    end else if (!enable) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!fault_r) begin
            state_nxt_s = ST_BLANK;
            blank_nxt_s = config_blanktime;
            on_nxt_s    = {MINON_W{1'b0}};
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BLANK: begin
          on_nxt_s = on_inc_s;
          if (blank_cnt_r <= BLANK_ONE) begin
            state_nxt_s = ST_ON;
            blank_nxt_s = {BLANK_W{1'b0}};
          end else begin
            blank_nxt_s = blank_cnt_r - BLANK_ONE;
          end
        end
        ST_ON: begin
          on_nxt_s = on_inc_s;
          if (cmp_sync_r) begin
            if (on_cnt_r < config_minon) begin
              state_nxt_s = ST_FAULT;
              trip_s      = 1'b1;
            end else begin
              off_nxt_s   = config_offtime;
              state_nxt_s = (config_offtime >= config_fastdecay_threshold) ? ST_FAST : ST_SLOW;
            end
          end else begin
            state_nxt_s = ST_ON;
          end
        end
        ST_FAST, ST_SLOW: begin
          if (off_cnt_r <= OFF_ONE) begin
            state_nxt_s = ST_BLANK;
            blank_nxt_s = config_blanktime;
            on_nxt_s    = {MINON_W{1'b0}};
            off_nxt_s   = {OFFTIME_W{1'b0}};
          end else begin
            off_nxt_s   = off_dec_s;
            state_nxt_s = (off_dec_s >= config_fastdecay_threshold) ? ST_FAST : ST_SLOW;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Sticky fault: a new trip wins over a simultaneous clear.
  always_comb begin
    if (trip_s) begin
      fault_nxt_s = 1'b1;
    end else if (clear_fault) begin
      fault_nxt_s = 1'b0;
    end else begin
      fault_nxt_s = fault_r;
    end
  end

  // FSM state, counters and sticky fault registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      blank_cnt_r <= {BLANK_W{1'b0}};
      on_cnt_r    <= {MINON_W{1'b0}};
      off_cnt_r   <= {OFFTIME_W{1'b0}};
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      blank_cnt_r <= blank_nxt_s;
      on_cnt_r    <= on_nxt_s;
      off_cnt_r   <= off_nxt_s;
      fault_r     <= fault_nxt_s;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_leg
    leg_t              tgt_s;
    leg_t              out_r;
    leg_t              out_nxt_s;
    leg_t              pend_r;
    leg_t              pend_nxt_s;
    logic [DEAD_W-1:0] dt_r;
    logic [DEAD_W-1:0] dt_nxt_s;
    logic              h_r;
    logic              l_r;

    // Leg target from the chopper state; never both sides on.
    always_comb begin
      tgt_s = LEG_OFF;
      if (force_off) begin
        tgt_s = LEG_OFF;
      end else begin
        case (state_r)
          ST_BLANK, ST_ON: tgt_s = cmd_to_leg(cmd[k]);
          ST_FAST:         tgt_s = cmd_to_leg(~cmd[k]);
          ST_SLOW:         tgt_s = LEG_LOW;
          default:         tgt_s = LEG_OFF;
        endcase
      end
    end

    // Dead-time sequencer: turning off is immediate; turning a side on
    // waits config_deadtime both-off cycles, restarted if the target moves.
    always_comb begin
      out_nxt_s  = out_r;
      pend_nxt_s = pend_r;
      dt_nxt_s   = dt_r;
      if (tgt_s == LEG_OFF) begin
        out_nxt_s  = LEG_OFF;
        pend_nxt_s = LEG_OFF;
        dt_nxt_s   = DEAD_ZERO;
      end else if ((dt_r != DEAD_ZERO) && (tgt_s == pend_r)) begin
        if (dt_r == DEAD_ONE) begin
          out_nxt_s = tgt_s;
          dt_nxt_s  = DEAD_ZERO;
        end else begin
          dt_nxt_s = dt_r - DEAD_ONE;
        end
      end else if ((dt_r == DEAD_ZERO) && (tgt_s == out_r)) begin
        pend_nxt_s = tgt_s;
      end else if (config_deadtime == DEAD_ZERO) begin
        out_nxt_s  = tgt_s;
        pend_nxt_s = tgt_s;
        dt_nxt_s   = DEAD_ZERO;
      end else begin
        out_nxt_s  = LEG_OFF;
        pend_nxt_s = tgt_s;
        dt_nxt_s   = config_deadtime;
      end
    end

    // Leg sequencer state and registered gate drives.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        out_r  <= LEG_OFF;
        pend_r <= LEG_OFF;
        dt_r   <= DEAD_ZERO;
        h_r    <= 1'b0;
        l_r    <= 1'b0;
      end else begin
        out_r  <= out_nxt_s;
        pend_r <= pend_nxt_s;
        dt_r   <= dt_nxt_s;
        h_r    <= (out_nxt_s == LEG_HIGH);
        l_r    <= (out_nxt_s == LEG_LOW);
      end
    end

    assign h_on[k] = h_r;
    assign l_on[k] = l_r;
  end

endmodule

// File: rtl/microstepper_chopper_nch.sv
// N-channel microstepper chopper / gate controller.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   enable                      run the choppers; 0 = all gates off
//   s_cmd[2*NUM_CH]             commanded polarity, bit 2c+k = channel c leg k
//   analog_cmp[NUM_CH]          asynchronous peak-current comparators
//   config_*                    shared timing configuration
//   config_invert_highside/low  output polarity of the s_h / s_l pins
//   clear_fault                 clears all sticky channel faults
//   s_h, s_l[2*NUM_CH]          gate pins
//   fault_ch[NUM_CH], fault     sticky per-channel faults and their OR
module microstepper_chopper_nch
  import microstepper_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int OFFTIME_W = DEF_OFFTIME_W,
  parameter int BLANK_W   = DEF_BLANK_W,
  parameter int MINON_W   = DEF_MINON_W,
  parameter int DEAD_W    = DEF_DEAD_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [2*NUM_CH-1:0]   s_cmd,
  input  logic [NUM_CH-1:0]     analog_cmp,
  input  logic [OFFTIME_W-1:0]  config_offtime,
  input  logic [OFFTIME_W-1:0]  config_fastdecay_threshold,
  input  logic [BLANK_W-1:0]    config_blanktime,
  input  logic [MINON_W-1:0]    config_minon,
  input  logic [DEAD_W-1:0]     config_deadtime,
  input  logic                  config_invert_highside,
  input  logic                  config_invert_lowside,
  input  logic                  clear_fault,
  output logic [2*NUM_CH-1:0]   s_h,
  output logic [2*NUM_CH-1:0]   s_l,
  output logic [NUM_CH-1:0]     fault_ch,
  output logic                  fault
);

  logic [2*NUM_CH-1:0] h_on_s;
  logic [2*NUM_CH-1:0] l_on_s;
  logic [2*NUM_CH-1:0] gate_mask_s;
  logic [NUM_CH-1:0]   fault_ch_s;
  logic                any_fault_s;

  assign any_fault_s = |fault_ch_s;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    microstepper_chopper_channel #(
      .OFFTIME_W (OFFTIME_W),
      .BLANK_W   (BLANK_W),
      .MINON_W   (MINON_W),
      .DEAD_W    (DEAD_W)
    ) u_channel (
      .clk                        (clk),
      .resetn                     (resetn),
      .enable                     (enable),
      .cmd                        (s_cmd[2*c +: 2]),
      .cmp_async                  (analog_cmp[c]),
      .force_off                  (any_fault_s),
      .config_offtime             (config_offtime),
      .config_fastdecay_threshold (config_fastdecay_threshold),
      .config_blanktime           (config_blanktime),
      .config_minon               (config_minon),
      .config_deadtime            (config_deadtime),
      .clear_fault                (clear_fault),
      .h_on                       (h_on_s[2*c +: 2]),
      .l_on                       (l_on_s[2*c +: 2]),
      .fault_ch                   (fault_ch_s[c])
    );
  end

  // The mask kills every gate in the same cycle a fault is flagged; the
  // force_off path then brings the gate registers themselves to off.
  assign gate_mask_s = {(2*NUM_CH){~any_fault_s}};
  assign s_h         = {(2*NUM_CH){config_invert_highside}} ^ (h_on_s & gate_mask_s);
  assign s_l         = {(2*NUM_CH){config_invert_lowside}} ^ (l_on_s & gate_mask_s);
  assign fault_ch    = fault_ch_s;
  assign fault       = any_fault_s;

endmodule

// File: tb/tb_microstepper_chopper_nch.sv
module tb_microstepper_chopper_nch;

  localparam int M_IDLE = 0, M_BLANK = 1, M_ON = 2, M_FAST = 3, M_SLOW = 4, M_FAULT = 5;
  localparam int SIDE_OFF = 0, SIDE_HIGH = 1, SIDE_LOW = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic [3:0] s_cmd;
  logic [1:0] analog_cmp;
  logic [9:0] config_offtime;
  logic [9:0] config_fastdecay_threshold;
  logic [7:0] config_blanktime;
  logic [7:0] config_minon;
  logic [3:0] config_deadtime;
  logic       config_invert_highside;
  logic       config_invert_lowside;
  logic       clear_fault;
  logic [3:0] s_h;
  logic [3:0] s_l;
  logic [1:0] fault_ch;
  logic       fault;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (phase + elapsed time per channel, applied side per leg)
  int m_phase[2];
  int m_blank_el[2], m_blank_len[2];
  int m_on[2];
  int m_off_el[2], m_off_load[2];
  bit m_fault[2];
  bit m_sync1[2], m_sync2[2];
  int m_side[4], m_dtgt[4], m_dleft[4];

  microstepper_chopper_nch dut (
    .clk                        (clk),
    .resetn                     (resetn),
    .enable                     (enable),
    .s_cmd                      (s_cmd),
    .analog_cmp                 (analog_cmp),
    .config_offtime             (config_offtime),
    .config_fastdecay_threshold (config_fastdecay_threshold),
    .config_blanktime           (config_blanktime),
    .config_minon               (config_minon),
    .config_deadtime            (config_deadtime),
    .config_invert_highside     (config_invert_highside),
    .config_invert_lowside      (config_invert_lowside),
    .clear_fault                (clear_fault),
    .s_h                        (s_h),
    .s_l                        (s_l),
    .fault_ch                   (fault_ch),
    .fault                      (fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_phase[c] = M_IDLE; m_blank_el[c] = 0; m_blank_len[c] = 1; m_on[c] = 0;
      m_off_el[c] = 0; m_off_load[c] = 0; m_fault[c] = 1'b0;
      m_sync1[c] = 1'b0; m_sync2[c] = 1'b0;
    end
    for (int l = 0; l < 4; l++) begin
      m_side[l] = SIDE_OFF; m_dtgt[l] = SIDE_OFF; m_dleft[l] = 0;
    end
  endtask

  function automatic int model_target(input int c, input bit cmd_bit, input bit any_f);
    if (any_f) return SIDE_OFF;
    case (m_phase[c])
      M_BLANK, M_ON: return cmd_bit ? SIDE_HIGH : SIDE_LOW;
      M_FAST:        return cmd_bit ? SIDE_LOW : SIDE_HIGH;
      M_SLOW:        return SIDE_LOW;
      default:       return SIDE_OFF;
    endcase
  endfunction

  task automatic enter_blank(input int c);
    m_phase[c] = M_BLANK;
    m_blank_el[c] = 0;
    m_blank_len[c] = (config_blanktime == 8'd0) ? 1 : int'(config_blanktime);
    m_on[c] = 0;
  endtask

  function automatic int off_phase(input int c);
    return ((m_off_load[c] - m_off_el[c]) >= int'(config_fastdecay_threshold)) ? M_FAST : M_SLOW;
  endfunction

  // One clock edge of the reference model, using pre-edge state and current inputs.
  task automatic model_step();
    bit any_f;
    int t;
    int off_len;
    if (!resetn) begin
      model_reset();
    end else begin
      any_f = m_fault[0] | m_fault[1];
      for (int l = 0; l < 4; l++) begin
        t = model_target(l / 2, s_cmd[l], any_f);
        if (t == SIDE_OFF) begin
          m_side[l] = SIDE_OFF; m_dleft[l] = 0; m_dtgt[l] = SIDE_OFF;
        end else if (m_dleft[l] > 0 && t == m_dtgt[l]) begin
          m_dleft[l]--;
          if (m_dleft[l] == 0) m_side[l] = t;
        end else if (m_dleft[l] == 0 && t == m_side[l]) begin
          m_dtgt[l] = t;
        end else if (config_deadtime == 4'd0) begin
          m_side[l] = t; m_dtgt[l] = t; m_dleft[l] = 0;
        end else begin
          m_side[l] = SIDE_OFF; m_dtgt[l] = t; m_dleft[l] = int'(config_deadtime);
        end
      end
      for (int c = 0; c < 2; c++) begin
        if (m_phase[c] == M_FAULT) begin
          if (clear_fault) begin
            m_phase[c] = M_IDLE; m_fault[c] = 1'b0;
          end
        end else if (!enable) begin
          m_phase[c] = M_IDLE;
        end else begin
          case (m_phase[c])
            M_IDLE: enter_blank(c);
            M_BLANK: begin
              m_on[c] = (m_on[c] < 255) ? m_on[c] + 1 : 255;
              m_blank_el[c]++;
              if (m_blank_el[c] >= m_blank_len[c]) m_phase[c] = M_ON;
            end
            M_ON: begin
              if (m_sync2[c]) begin
                if (m_on[c] < int'(config_minon)) begin
                  m_phase[c] = M_FAULT; m_fault[c] = 1'b1;
                end else begin
                  m_off_load[c] = int'(config_offtime); m_off_el[c] = 0;
                  m_phase[c] = off_phase(c);
                end
              end
              m_on[c] = (m_on[c] < 255) ? m_on[c] + 1 : 255;
            end
            default: begin
              m_off_el[c]++;
              off_len = (m_off_load[c] == 0) ? 1 : m_off_load[c];
              if (m_off_el[c] >= off_len) enter_blank(c);
              else m_phase[c] = off_phase(c);
            end
          endcase
        end
        m_sync2[c] = m_sync1[c];
        m_sync1[c] = analog_cmp[c];
      end
    end
  endtask

  task automatic compare_all();
    bit any_now;
    logic [3:0] eh, el;
    any_now = m_fault[0] | m_fault[1];
    for (int l = 0; l < 4; l++) begin
      eh[l] = !any_now && (m_side[l] == SIDE_HIGH);
      el[l] = !any_now && (m_side[l] == SIDE_LOW);
    end
    check_eq("s_h", s_h, eh ^ {4{config_invert_highside}});
    check_eq("s_l", s_l, el ^ {4{config_invert_lowside}});
    check_eq("fault_ch", fault_ch, {m_fault[1], m_fault[0]});
    check_eq("fault", fault, any_now);
    check_eq("no_shoot", (s_h ^ {4{config_invert_highside}}) & (s_l ^ {4{config_invert_lowside}}), 4'b0000);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_phase(input int c, input int ph, input int budget);
    int n;
    n = 0;
    while (m_phase[c] != ph && n < budget) begin
      tick();
      n++;
    end
    if (m_phase[c] != ph) check_eq("wait_phase", m_phase[c], ph);
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b1; s_cmd = 4'b0001; analog_cmp = 2'b00;
    config_offtime = 10'd10; config_fastdecay_threshold = 10'd6; config_blanktime = 8'd4;
    config_minon = 8'd2; config_deadtime = 4'd2;
    config_invert_highside = 1'b0; config_invert_lowside = 1'b0; clear_fault = 1'b0;
    model_reset();
    #2;
    check_eq("rst_sh", s_h, 4'h0);
    check_eq("rst_sl", s_l, 4'h0);
    check_eq("rst_fault", fault, 1'b0);
    config_invert_highside = 1'b1; config_invert_lowside = 1'b1;
    #1;
    check_eq("rst_sh_inv", s_h, 4'hF);
    check_eq("rst_sl_inv", s_l, 4'hF);
    config_invert_highside = 1'b0; config_invert_lowside = 1'b0;
    @(negedge clk);
    tick(); tick();
    resetn = 1'b1;

    // Basic chop cycle on ch0: blank, on, fast decay, slow decay.
    wait_phase(0, M_ON, 20);
    check_eq("on_s_h", s_h, 4'b0001);
    check_eq("on_s_l", s_l, 4'b1110);
    analog_cmp = 2'b01;
    wait_phase(0, M_FAST, 6);
    analog_cmp = 2'b00;
    tick(); tick(); tick();
    check_eq("fast_s_h", s_h, 4'b0010);
    check_eq("fast_s_l", s_l, 4'b1101);
    wait_phase(0, M_SLOW, 6);
    tick(); tick(); tick();
    check_eq("slow_s_h", s_h, 4'b0000);
    check_eq("slow_s_l", s_l, 4'b1111);
    wait_phase(0, M_ON, 20);

    // Disable mid-ON: gates off one cycle after the FSM drops to IDLE.
    enable = 1'b0;
    tick(); tick();
    check_eq("en_off_h", s_h, 4'h0);
    check_eq("en_off_l", s_l, 4'h0);

    // Re-enable with a long minimum on time: blank pulse ignored, early trip faults.
    config_minon = 8'd8;
    enable = 1'b1;
    wait_phase(0, M_BLANK, 4);
    analog_cmp = 2'b01;
    tick();
    analog_cmp = 2'b00;
    wait_phase(0, M_ON, 10);
    check_eq("blank_ignored", fault, 1'b0);
    analog_cmp = 2'b01;
    wait_phase(0, M_FAULT, 8);
    analog_cmp = 2'b00;
    check_eq("trip_fault_ch", fault_ch, 2'b01);
    check_eq("trip_fault", fault, 1'b1);
    check_eq("trip_s_h", s_h, 4'h0);
    check_eq("trip_s_l", s_l, 4'h0);
    tick(); tick();
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check_eq("clear_fault", fault, 1'b0);
    wait_phase(0, M_BLANK, 4);

    // Toggle leg0 command every cycle with a 3-cycle dead time: leg stays off.
    config_minon = 8'd2;
    config_deadtime = 4'd3;
    for (int i = 0; i < 16; i++) begin
      s_cmd[0] = ~s_cmd[0];
      tick();
      if (i >= 1) check_eq("toggle_leg0_off", {s_h[0], s_l[0]}, 2'b00);
    end
    config_deadtime = 4'd2;

    // Asynchronous reset in the middle of fast decay.
    wait_phase(0, M_ON, 30);
    analog_cmp = 2'b01;
    wait_phase(0, M_FAST, 6);
    analog_cmp = 2'b00;
    tick(); tick(); tick();
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_eq("arst_s_h", s_h, 4'h0);
    check_eq("arst_s_l", s_l, 4'h0);
    check_eq("arst_fault", fault, 1'b0);
    tick(); tick();
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    // Randomised operation against the reference model.
    for (int i = 0; i < 900; i++) begin
      if (i % 100 == 0) begin
        config_blanktime = 8'($urandom_range(0, 6));
        config_minon = 8'($urandom_range(0, 8));
        config_offtime = 10'($urandom_range(0, 12));
        config_fastdecay_threshold = 10'($urandom_range(0, 14));
        config_deadtime = 4'($urandom_range(0, 3));
        config_invert_highside = 1'($urandom_range(0, 1));
        config_invert_lowside = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 7) == 0) s_cmd = 4'($urandom_range(0, 15));
      analog_cmp[0] = ($urandom_range(0, 9) < 2);
      analog_cmp[1] = ($urandom_range(0, 9) < 2);
      enable = ($urandom_range(0, 39) != 0);
      clear_fault = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
